rx_scramble_ctrl: RTL
=====================

RX_SCRAMBLE_CTRL -- requirements
Module: RxScrambleCtrl

Interface
REQ-001 SHALL have port ClkPci  input  1  Rx symbol clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port DecodeByte  input  8  decoded symbol from the 8b10b decoder, valid in the same cycle as DecodeCtrl.
REQ-004 SHALL have port DecodeCtrl  input  1  1 = DecodeByte is a K symbol, 0 = D symbol.
REQ-005 SHALL have port DecodeValid  input  1  1 = a symbol is presented this cycle.
REQ-006 SHALL have port DisableScramble  input  1  link-level scrambling disable from training control.
REQ-007 SHALL have port NextScXor  output  8  descramble mask for the symbol currently on DecodeByte, consumed by the Rx data path.
REQ-008 SHALL have port NextScramble  output  1  1 = apply NextScXor to the current symbol.
REQ-009 SHALL have port Locked  output  1  1 = at least one COM seen since reset.
REQ-010 SHALL have port InOrdSet  output  1  1 = current state is an ordered-set state.

Function
REQ-011 SHALL hold a 16-bit Galois LFSR, polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF.
REQ-012 SHALL drive NextScXor combinationally from the registered LFSR: bit i = LFSR bit 15 after i single shifts (i = 0..7), i.e. the mask aligns with the DecodeByte presented in the same cycle.
REQ-013 SHALL advance the LFSR by 8 shifts per valid symbol, except: COM (K, 8'hBC) loads 16'hFFFF; SKP (K, 8'h1C) leaves it unchanged; DecodeValid=0 leaves it unchanged.
REQ-014 SHALL implement states UNLOCKED, DATA, OS_FIRST, KSET, TSSET.
REQ-015 UNLOCKED: LFSR held at 16'hFFFF, NextScramble=0; valid COM -> OS_FIRST; all other symbols ignored.
REQ-016 DATA: valid COM -> OS_FIRST; any other symbol stays in DATA.
REQ-017 OS_FIRST (symbol after COM): K symbol other than PAD (8'hF7) -> KSET; D symbol or PAD -> TSSET with a 4-bit counter loaded to 14.
REQ-018 KSET (SKP/FTS/IDL sets): stays while symbol is K and not COM; D symbol -> DATA, and that symbol is itself treated as a DATA symbol (scrambled per REQ-021).
REQ-019 TSSET: counter decrements per valid symbol; the symbol seen at counter 0 is the last TS symbol and the state moves to DATA on the next edge; 16 symbols total including COM.
REQ-020 COM in any state, including mid-TSSET or mid-KSET, SHALL reload the LFSR and go to OS_FIRST; COM takes priority over counter expiry.
REQ-021 NextScramble SHALL be 1 only when DecodeValid=1, DecodeCtrl=0, DisableScramble=0, and the effective state is DATA; KSET followed by a D symbol counts as DATA. Otherwise 0.
REQ-022 K symbols SHALL never be descrambled; the LFSR still advances on non-SKP, non-COM K symbols.
REQ-023 DisableScramble SHALL affect only NextScramble; LFSR and state tracking continue unchanged.
REQ-024 Locked SHALL set on the first valid COM and clear only on Reset; InOrdSet = 1 in OS_FIRST, KSET and TSSET.
REQ-025 DecodeValid=0 SHALL freeze state, counter and LFSR, with NextScramble=0.

Reset
REQ-026 Reset SHALL give: state UNLOCKED, LFSR 16'hFFFF, counter 0, Locked=0, InOrdSet=0, NextScramble=0, NextScXor=8'hFF; Reset SHALL override all other inputs in the same cycle.
REQ-027 Reset asserted mid-operation SHALL discard lock; re-lock SHALL require a new COM.

Verification
REQ-028 Reset, then D 8'h00 x4 with no COM -> NextScramble=0 every cycle, Locked=0, NextScXor=8'hFF.
REQ-029 COM, then D symbols x8 -> NextScramble=1 from the first D symbol; NextScXor = FF,17,C0,14,B2,E7,02,82.
REQ-030 COM, SKP, SKP, SKP, then D x2 -> InOrdSet=1 over the 4 set symbols; masks on the D symbols = FF,17 (no LFSR advance on SKP).
REQ-031 TS1 (COM, PAD, PAD, then 13 D 8'h4A), then D -> NextScramble=0 for all 16 TS symbols; the following D symbol is scrambled with the mask the LFSR reaches after 15 advances from FFFF.
REQ-032 COM arriving at TSSET counter 5 -> LFSR=FFFF, state OS_FIRST; next D symbol has mask FF; DisableScramble=1 during DATA -> NextScramble=0 while masks continue.
REQ-033 Reset asserted for one cycle in DATA -> Locked=0 next cycle; D symbols unscrambled until the next COM.

Source files
------------

// File: rtl/rx_scramble_ctrl.sv
// -----------------------------------------------------------------------------
// rx_scramble_ctrl
//
// Receive-side descrambler control for a PCIe-style 8b10b link. Tracks the
// ordered-set structure of the incoming symbol stream and keeps the 16-bit
// Galois descrambling LFSR (x^16 + x^5 + x^4 + x^3 + 1) in step with the
// far-end scrambler. The descramble mask for the symbol presented this cycle
// is produced combinationally from the registered LFSR so the Rx data path can
// apply it in the same cycle.
//
// Ports
//   ClkPci          in   1  Rx symbol clock, all state updates on rising edge
//   Reset           in   1  synchronous, active-high reset
//   DecodeByte      in   8  decoded symbol from the 8b10b decoder
//   DecodeCtrl      in   1  1 = K symbol, 0 = D symbol
//   DecodeValid     in   1  1 = a symbol is presented this cycle
//   DisableScramble in   1  link-level scrambling disable
//   NextScXor       out  8  descramble mask for the current DecodeByte
//   NextScramble    out  1  1 = apply NextScXor to the current symbol
//   Locked          out  1  1 = at least one COM seen since reset
//   InOrdSet        out  1  1 = current state is an ordered-set state
// -----------------------------------------------------------------------------
module rx_scramble_ctrl (
  input  logic       ClkPci,
  input  logic       Reset,
  input  logic [7:0] DecodeByte,
  input  logic       DecodeCtrl,
  input  logic       DecodeValid,
  input  logic       DisableScramble,
  output logic [7:0] NextScXor,
  output logic       NextScramble,
  output logic       Locked,
  output logic       InOrdSet
);

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_TAPS = 16'h0039;  // x^5, x^4, x^3, x^0
  localparam logic [7:0]  SYM_COM   = 8'hBC;
  localparam logic [7:0]  SYM_SKP   = 8'h1C;
  localparam logic [7:0]  SYM_PAD   = 8'hF7;
  // Symbols still to come in TSSET after the OS_FIRST symbol (16 total
  // including COM and the OS_FIRST symbol).
  localparam logic [3:0]  TS_REMAIN = 4'd14;

  typedef enum logic [2:0] {
    ST_UNLOCKED = 3'd0,
    ST_DATA     = 3'd1,
    ST_OS_FIRST = 3'd2,
    ST_KSET     = 3'd3,
    ST_TSSET    = 3'd4
  } state_t;

  // One Galois shift: MSB is the output bit and feeds back into the taps.
  function automatic logic [15:0] lfsr_shift1(input logic [15:0] s);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) begin
      n = n ^ LFSR_TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Advance by one symbol (eight shifts).
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = lfsr_shift1(t);
    end
    return t;
  endfunction

  // Mask bit i is the MSB after i shifts, so bit 0 is the first output bit.
  function automatic logic [7:0] lfsr_mask(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  m;
    t = s;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = t[15];
      t    = lfsr_shift1(t);
    end
    return m;
  endfunction

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [3:0]  r_cnt;
  logic        r_locked;

  state_t      w_state_nxt;
  logic [15:0] w_lfsr_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_locked_nxt;

  logic        w_is_com;
  logic        w_is_skp;
  logic        w_is_pad;

  assign w_is_com = DecodeValid & DecodeCtrl & (DecodeByte == SYM_COM);
  assign w_is_skp = DecodeValid & DecodeCtrl & (DecodeByte == SYM_SKP);
  assign w_is_pad = DecodeValid & DecodeCtrl & (DecodeByte == SYM_PAD);

  // Next-state, LFSR and TS counter update.
  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_cnt_nxt    = r_cnt;
    w_locked_nxt = r_locked;

    if (!DecodeValid) begin
      // No symbol: everything holds.
      w_state_nxt = r_state;
    end else if (w_is_com) begin
      // COM re-aligns from any state and wins over TS counter expiry.
      w_state_nxt  = ST_OS_FIRST;
      w_lfsr_nxt   = LFSR_SEED;
      w_cnt_nxt    = 4'd0;
      w_locked_nxt = 1'b1;
    end else begin
      // The far-end scrambler does not advance on SKP; before lock the
      // LFSR is pinned to the seed.
      if (r_state == ST_UNLOCKED) begin
        w_lfsr_nxt = LFSR_SEED;
      end else if (w_is_skp) begin
        w_lfsr_nxt = r_lfsr;
      end else begin
        w_lfsr_nxt = lfsr_adv8(r_lfsr);
      end

      case (r_state)
        ST_UNLOCKED: w_state_nxt = ST_UNLOCKED;
        ST_DATA:     w_state_nxt = ST_DATA;
        ST_OS_FIRST: begin
          // PAD after COM only appears in TS1/TS2 (link/lane number).
          if (DecodeCtrl && !w_is_pad) begin
            w_state_nxt = ST_KSET;
          end else begin
            w_state_nxt = ST_TSSET;
            w_cnt_nxt   = TS_REMAIN;
          end
        end
        ST_KSET: begin
          if (!DecodeCtrl) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_KSET;
          end
        end
        ST_TSSET: begin
          // The symbol that takes the counter to 0 is the last TS symbol.
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = ST_TSSET;
            w_cnt_nxt   = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_lfsr_nxt  = LFSR_SEED;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset overriding all inputs.
  always_ff @(posedge ClkPci) begin
    if (Reset) begin
      r_state  <= ST_UNLOCKED;
      r_lfsr   <= LFSR_SEED;
      r_cnt    <= 4'd0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  // Descramble enable: a D symbol in KSET ends the set and is itself data.
  always_comb begin
    NextScramble = 1'b0;
    if (DecodeValid && !DecodeCtrl && !DisableScramble &&
        ((r_state == ST_DATA) || (r_state == ST_KSET))) begin
      NextScramble = 1'b1;
    end else begin
      NextScramble = 1'b0;
    end
  end

  assign NextScXor = lfsr_mask(r_lfsr);
  assign Locked    = r_locked;
  assign InOrdSet  = (r_state == ST_OS_FIRST) || (r_state == ST_KSET) ||
                     (r_state == ST_TSSET);

endmodule
